// File: rtl/serial_exp_adder.sv
// Bit-serial W-bit adder with optional serial bias removal.
// One full-adder cell handles both passes: A+B first, then (A+B) + ~BIAS + 1.
// Result bits are written in place at the current bit index, LSB first.
module serial_exp_adder #(
  parameter int unsigned W    = 8,
  parameter int unsigned BIAS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         borrow
);

  localparam int unsigned      CW     = $clog2(W);
  localparam logic [W-1:0]     BIAS_W = W'(BIAS);
  localparam logic [W-1:0]     NBIAS  = ~BIAS_W;
  localparam logic [CW-1:0]    LAST   = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_BSUB,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          borrow_q, borrow_d;
  logic          start_ready_q;
  logic          out_valid_q;

  logic          fa_x, fa_y, fa_s, fa_c;

  // Full-adder cell; operands are A/B in the add pass, result/~BIAS in the bias pass.
  always_comb begin
    fa_x = res_q[cnt_q];
    fa_y = NBIAS[cnt_q];
    if (state_q == S_ADD) begin
      fa_x = a_q[cnt_q];
      fa_y = b_q[cnt_q];
    end
    fa_s = fa_x ^ fa_y ^ carry_q;
    fa_c = (fa_x & fa_y) | (fa_x & carry_q) | (fa_y & carry_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          carry_d  = 1'b0;
          cout_d   = 1'b0;
          borrow_d = 1'b0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        res_d[cnt_q] = fa_s;
        carry_d      = fa_c;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d = fa_c;
          if (BIAS_W == '0) begin
            state_d = S_DONE;
          end else begin
            carry_d = 1'b1;
            cnt_d   = '0;
            state_d = S_BSUB;
          end
        end
      end
      S_BSUB: begin
        res_d[cnt_q] = fa_s;
        carry_d      = fa_c;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          borrow_d = ~fa_c;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      borrow_q      <= 1'b0;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      cout_q        <= cout_d;
      borrow_q      <= borrow_d;
      start_ready_q <= (state_d == S_IDLE);
      out_valid_q   <= (state_d == S_DONE);
    end
  end

  assign start_ready = start_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = res_q;
  assign cout        = cout_q;
  assign borrow      = borrow_q;

endmodule

// File: tb/tb_serial_exp_adder.sv
// Bench for serial_exp_adder: one instance with BIAS=0, one with BIAS=127.
module tb_serial_exp_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sv, sr, ov, ordy, co, bo;
  logic [1:0][7:0] av, bv, res;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_exp_adder #(.W(8), .BIAS(0)) u_b0 (
    .clk(clk), .rst(rst),
    .start_valid(sv[0]), .start_ready(sr[0]),
    .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res[0]), .cout(co[0]), .borrow(bo[0])
  );

  serial_exp_adder #(.W(8), .BIAS(127)) u_b127 (
    .clk(clk), .rst(rst),
    .start_valid(sv[1]), .start_ready(sr[1]),
    .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res[1]), .cout(co[1]), .borrow(bo[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: plain integer arithmetic on the whole words.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input int bias);
    int s, r, d;
    logic c, bw;
    s  = int'(x) + int'(y);
    c  = (s > 255);
    r  = s % 256;
    bw = (r < bias);
    d  = (r + 256 - bias) % 256;
    return {bw, c, 8'(d)};
  endfunction

  // One full transaction: handshake in, latency, optional hold with pokes, release.
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                        input int hold, input bit poke,
                        output logic [7:0] r, output logic c, output logic bw);
    int n;
    n = 0;
    while (!sr[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_wait", 32'(sr[d]), 32'd1);
    sv[d] = 1'b1;
    av[d] = x;
    bv[d] = y;
    @(negedge clk);
    sv[d] = 1'b0;
    av[d] = 8'($urandom);
    bv[d] = 8'($urandom);
    check("busy_after_accept", 32'(sr[d]), 32'd0);
    n = 0;
    while (!ov[d] && n < 100) begin
      sv[d]   = (poke && n == 2);
      ordy[d] = (n == 3);
      if (poke && n == 2) begin
        av[d] = 8'h11;
        bv[d] = 8'h22;
      end
      @(negedge clk);
      n++;
    end
    sv[d]   = 1'b0;
    ordy[d] = 1'b0;
    check("latency", 32'(n), (d == 0) ? 32'd8 : 32'd16);
    r  = res[d];
    c  = co[d];
    bw = bo[d];
    for (int k = 0; k < hold; k++) begin
      sv[d] = poke;
      av[d] = 8'($urandom);
      bv[d] = 8'($urandom);
      @(negedge clk);
      check("hold_result", 32'(res[d]), 32'(r));
      check("hold_flags", 32'({co[d], bo[d], ov[d], sr[d]}), 32'({c, bw, 1'b1, 1'b0}));
    end
    sv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    check("release_out_valid", 32'(ov[d]), 32'd0);
    check("release_start_ready", 32'(sr[d]), 32'd1);
  endtask

  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic       ec;
    logic       eb;
    int         hold;
    bit         poke;
  } vec_t;

  vec_t       vt[7];
  logic [7:0] r;
  logic       c, bw;
  logic [9:0] m;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0, 0,  1'b0};
    vt[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0,  1'b0};
    vt[2] = '{0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0,  1'b0};
    vt[3] = '{1, 8'h40, 8'h50, 8'h11, 1'b0, 1'b0, 0,  1'b0};
    vt[4] = '{1, 8'h85, 8'h80, 8'h86, 1'b1, 1'b1, 0,  1'b0};
    vt[5] = '{0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0, 20, 1'b1};
    vt[6] = '{1, 8'h85, 8'h80, 8'h86, 1'b1, 1'b1, 20, 1'b1};

    sv = '0; ordy = '0; av = '0; bv = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_start_ready", 32'(sr[d]), 32'd1);
      check("reset_outputs", 32'({ov[d], co[d], bo[d], res[d]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, including backpressure and busy pokes.
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].d, vt[i].a, vt[i].b, vt[i].hold, vt[i].poke, r, c, bw);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].er));
      check($sformatf("vec%0d_cout_borrow", i), 32'({c, bw}), 32'({vt[i].ec, vt[i].eb}));
    end

    // Reset in the middle of the add pass, after three bits.
    while (!sr[0]) @(negedge clk);
    sv[0] = 1'b1; av[0] = 8'hAA; bv[0] = 8'h55;
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_start_ready", 32'(sr[0]), 32'd1);
    check("midreset_outputs", 32'({ov[0], co[0], bo[0], res[0]}), 32'd0);
    @(negedge clk);
    check("midreset_held_idle", 32'({sr[0], ov[0]}), 32'b10);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 8'h01, 8'h01, 0, 1'b0, r, c, bw);
    check("after_reset_result", 32'(r), 32'h02);
    check("after_reset_flags", 32'({c, bw}), 32'd0);

    // Randomized operations against the integer model.
    for (int i = 0; i < 40; i++) begin
      int         d;
      logic [7:0] x, y;
      d = int'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      run_op(d, x, y, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r, c, bw);
      m = model(x, y, (d == 0) ? 0 : 127);
      check($sformatf("rand%0d_result", i), 32'(r), 32'(m[7:0]));
      check($sformatf("rand%0d_cout_borrow", i), 32'({c, bw}), 32'({m[8], m[9]}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
